// File: rtl/mem_pkg.sv
// Shared constants for the shared-memory arbiter/sequencer: state encoding,
// requester (owner) encoding and datapath width.
package mem_pkg;

    localparam int DATA_W = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. One requester may be masked out, which
// lets the RESP cycle re-arbitrate without re-granting the finishing owner.
module rr_arb2
    import mem_pkg::*;
(
    input  logic req_if,
    input  logic req_dm,
    input  logic last_grant,
    input  logic exclude_valid,
    input  logic exclude_owner,
    output logic grant_valid,
    output logic grant_owner
);

    logic eff_if;
    logic eff_dm;

    assign eff_if = req_if & ~(exclude_valid & (exclude_owner == OWN_IF));
    assign eff_dm = req_dm & ~(exclude_valid & (exclude_owner == OWN_DM));

    assign grant_valid = eff_if | eff_dm;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_owner = OWN_IF;
        if (eff_if && eff_dm) begin
            grant_owner = ~last_grant;
        end else if (eff_dm) begin
            grant_owner = OWN_DM;
        end
    end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Arbitrates one single-port word memory between instruction fetch and data
// access. Optional misaligned-address rejection: MEM_ARB_ALIGN_CHK_EN.
module mem_arb_ctrl
    import mem_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    output logic              if_stall,
    input  logic              dm_rd,
    input  logic              dm_wr,
    input  logic [DATA_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              dm_stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err,
    output logic [1:0]        dbg_state
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    // Handshake: a requester raises its request and holds it, with stable
    // address/data, until its done pulse; stall = request & ~done. Inputs are
    // sampled only on the grant edge of each transaction.

    logic [1:0]        state;
    logic              owner;
    logic              last_grant;
    logic              lat_wr;
    logic [DATA_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  cnt;

    logic              dm_req;
    logic              arb_excl;
    logic              grant_valid;
    logic              grant_owner;
    logic              take_grant;
    logic [DATA_W-1:0] grant_addr;
    logic              grant_wr;
    logic              grant_misaligned;

    assign dm_req   = dm_rd | dm_wr;
    assign arb_excl = (state == ST_RESP);

    rr_arb2 u_arb (
        .req_if       (if_req),
        .req_dm       (dm_req),
        .last_grant   (last_grant),
        .exclude_valid(arb_excl),
        .exclude_owner(owner),
        .grant_valid  (grant_valid),
        .grant_owner  (grant_owner)
    );

    assign take_grant = grant_valid & ((state == ST_IDLE) | (state == ST_RESP));
    assign grant_addr = (grant_owner == OWN_DM) ? dm_addr : if_addr;
    assign grant_wr   = (grant_owner == OWN_DM) & dm_wr;

`ifdef MEM_ARB_ALIGN_CHK_EN
    logic lat_err;

    assign grant_misaligned = grant_addr[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_err <= 1'b0;
        end else if (take_grant) begin
            lat_err <= grant_misaligned;
        end
    end

    assign err = (state == ST_RESP) & lat_err;
`else
    assign grant_misaligned = 1'b0;
    assign err              = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= OWN_IF;
            last_grant <= OWN_IF;
            lat_wr     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_RESP: begin
                    if (take_grant) begin
                        owner      <= grant_owner;
                        last_grant <= grant_owner;
                        lat_addr   <= grant_addr;
                        lat_wr     <= grant_wr;
                        lat_wdata  <= dm_wdata;
                        cnt        <= CNT_INIT;
                        // A rejected request skips the memory entirely.
                        state      <= grant_misaligned ? ST_RESP : ST_ACCESS;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        if (!lat_wr) begin
                            if (owner == OWN_DM) begin
                                dm_rdata <= mem_rdata;
                            end else begin
                                if_rdata <= mem_rdata;
                            end
                        end
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_en    = (state == ST_ACCESS);
    assign mem_wr    = (state == ST_ACCESS) & lat_wr & (cnt == '0);
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    assign if_done  = (state == ST_RESP) & (owner == OWN_IF);
    assign dm_done  = (state == ST_RESP) & (owner == OWN_DM);
    assign if_stall = if_req & ~if_done;
    assign dm_stall = dm_req & ~dm_done;

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl (LATENCY=2) with a behavioural backing
// memory; build with MEM_ARB_ALIGN_CHK_EN to exercise the rejection path.
module tb_mem_arb_ctrl;

    localparam logic [1:0] S_I = 2'd0;
    localparam logic [1:0] S_A = 2'd1;
    localparam logic [1:0] S_R = 2'd2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_rd;
    logic        dm_wr;
    logic [15:0] dm_addr;
    logic [15:0] dm_wdata;
    logic [15:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        err;
    logic [1:0]  dbg_state;

    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    mem_arb_ctrl #(.LATENCY(2), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .if_stall (if_stall),
        .dm_rd    (dm_rd),
        .dm_wr    (dm_wr),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_done  (dm_done),
        .dm_stall (dm_stall),
        .mem_en   (mem_en),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .err      (err),
        .dbg_state(dbg_state)
    );

    // Backing memory: combinational read, write on the clock edge.
    logic [15:0] mem [0:65535];
    logic        mem_ready = 1'b0;

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
            mem[16'h0010] <= 16'hBEEF;
            mem[16'h0021] <= 16'h7777;
            mem[16'h0030] <= 16'hAAAA;
            mem_ready     <= 1'b1;
        end else if (mem_en && mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = mem[mem_addr];

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] flags();
        return {9'd0, mem_en, mem_wr, if_done, dm_done, if_stall, dm_stall, err};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input logic ifr, input logic [15:0] ifa, input logic dmr,
                         input logic dmw, input logic [15:0] dma, input logic [15:0] dmwd);
        if_req   = ifr;
        if_addr  = ifa;
        dm_rd    = dmr;
        dm_wr    = dmw;
        dm_addr  = dma;
        dm_wdata = dmwd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit check_outputs);
        rst = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk);
        @(negedge clk);
        if (check_outputs) begin
            check("reset_flags", flags(), 16'h0000);
            check("reset_if_rdata", if_rdata, 16'h0000);
            check("reset_dm_rdata", dm_rdata, 16'h0000);
            check("reset_mem_addr", mem_addr, 16'h0000);
            check("reset_mem_wdata", mem_wdata, 16'h0000);
            check("reset_state", {14'd0, dbg_state}, {14'd0, S_I});
        end
        rst = 1'b0;
        next_cycle();
    endtask

    // ---------------- vector table ----------------
    // fl bits: mem_en mem_wr if_done dm_done if_stall dm_stall err
    typedef struct {
        logic        ifr;
        logic [15:0] ifa;
        logic        dmr;
        logic        dmw;
        logic [15:0] dma;
        logic [15:0] dmwd;
        logic [6:0]  fl;
        logic [15:0] ifrd;
        logic [15:0] dmrd;
        logic [1:0]  st;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ifr, input logic [15:0] ifa, input logic dmr,
                                input logic dmw, input logic [15:0] dma, input logic [15:0] dmwd,
                                input logic [6:0] fl, input logic [15:0] ifrd,
                                input logic [15:0] dmrd, input logic [1:0] st);
        vec_t v;
        v.ifr = ifr; v.ifa = ifa; v.dmr = dmr; v.dmw = dmw; v.dma = dma; v.dmwd = dmwd;
        v.fl = fl; v.ifrd = ifrd; v.dmrd = dmrd; v.st = st;
        return v;
    endfunction

    initial begin
        rst = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);

        // IF read of 0x10, DM write then read of 0x20, IF read of 0x20,
        // then a rd+wr request that must behave as a write.
        vecs.push_back(mk(1, 16'h0010, 0, 0, 16'h0, 16'h0,    7'b0000100, 16'h0000, 16'h0000, S_I));
        vecs.push_back(mk(1, 16'h0010, 0, 0, 16'h0, 16'h0,    7'b1000100, 16'h0000, 16'h0000, S_A));
        vecs.push_back(mk(1, 16'h0010, 0, 0, 16'h0, 16'h0,    7'b1000100, 16'h0000, 16'h0000, S_A));
        vecs.push_back(mk(1, 16'h0010, 0, 0, 16'h0, 16'h0,    7'b0010000, 16'hBEEF, 16'h0000, S_R));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0, 16'h0,    7'b0000000, 16'hBEEF, 16'h0000, S_I));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h20, 16'h1234, 7'b0000010, 16'hBEEF, 16'h0000, S_I));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h20, 16'h1234, 7'b1000010, 16'hBEEF, 16'h0000, S_A));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h20, 16'h1234, 7'b1100010, 16'hBEEF, 16'h0000, S_A));
        vecs.push_back(mk(0, 16'h0000, 0, 1, 16'h20, 16'h1234, 7'b0001000, 16'hBEEF, 16'h0000, S_R));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h20, 16'h0,    7'b0000010, 16'hBEEF, 16'h0000, S_I));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h20, 16'h0,    7'b1000010, 16'hBEEF, 16'h0000, S_A));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h20, 16'h0,    7'b1000010, 16'hBEEF, 16'h0000, S_A));
        vecs.push_back(mk(0, 16'h0000, 1, 0, 16'h20, 16'h0,    7'b0001000, 16'hBEEF, 16'h1234, S_R));
        vecs.push_back(mk(1, 16'h0020, 0, 0, 16'h0, 16'h0,    7'b0000100, 16'hBEEF, 16'h1234, S_I));
        vecs.push_back(mk(1, 16'h0020, 0, 0, 16'h0, 16'h0,    7'b1000100, 16'hBEEF, 16'h1234, S_A));
        vecs.push_back(mk(1, 16'h0020, 0, 0, 16'h0, 16'h0,    7'b1000100, 16'hBEEF, 16'h1234, S_A));
        vecs.push_back(mk(1, 16'h0020, 0, 0, 16'h0, 16'h0,    7'b0010000, 16'h1234, 16'h1234, S_R));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0, 16'h0,    7'b0000000, 16'h1234, 16'h1234, S_I));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 16'h22, 16'h5A5A, 7'b0000010, 16'h1234, 16'h1234, S_I));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 16'h22, 16'h5A5A, 7'b1000010, 16'h1234, 16'h1234, S_A));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 16'h22, 16'h5A5A, 7'b1100010, 16'h1234, 16'h1234, S_A));
        vecs.push_back(mk(0, 16'h0000, 1, 1, 16'h22, 16'h5A5A, 7'b0001000, 16'h1234, 16'h1234, S_R));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 16'h0, 16'h0,    7'b0000000, 16'h1234, 16'h1234, S_I));

        do_reset(1'b1);

        foreach (vecs[i]) begin
            drive(vecs[i].ifr, vecs[i].ifa, vecs[i].dmr, vecs[i].dmw, vecs[i].dma, vecs[i].dmwd);
            @(negedge clk);
            check($sformatf("v%0d_flags", i), flags(), {9'd0, vecs[i].fl});
            check($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].ifrd);
            check($sformatf("v%0d_dm_rdata", i), dm_rdata, vecs[i].dmrd);
            check($sformatf("v%0d_state", i), {14'd0, dbg_state}, {14'd0, vecs[i].st});
            next_cycle();
        end
        check("mem_0x20_written", mem[16'h0020], 16'h1234);
        check("mem_0x22_rdwr_is_write", mem[16'h0022], 16'h5A5A);

        // Both requesters held high from reset: DM wins the first tie, then
        // strict alternation with a done every third cycle and no IDLE gap.
        do_reset(1'b0);
        drive(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, 16'h0);
        for (int c = 0; c <= 12; c++) begin
            logic [1:0] exp_st;
            logic       is_resp;
            is_resp = (c > 0) && (c % 3 == 0);
            exp_st  = (c == 0) ? S_I : (is_resp ? S_R : S_A);
            @(negedge clk);
            check($sformatf("tie_c%0d_state", c), {14'd0, dbg_state}, {14'd0, exp_st});
            check_bit($sformatf("tie_c%0d_mem_en", c), mem_en, exp_st == S_A);
            check_bit($sformatf("tie_c%0d_dm_done", c), dm_done, is_resp && ((c / 3) % 2 == 1));
            check_bit($sformatf("tie_c%0d_if_done", c), if_done, is_resp && ((c / 3) % 2 == 0));
            if (c != 12) next_cycle();
        end
        check("tie_dm_rdata", dm_rdata, 16'h1234);
        check("tie_if_rdata", if_rdata, 16'hBEEF);
        next_cycle();

        // Reset during the first ACCESS cycle of a DM write.
        do_reset(1'b0);
        drive(1'b0, 16'h0, 1'b0, 1'b1, 16'h0030, 16'h5555);
        @(negedge clk);
        check("rstmid_c0_flags", flags(), 16'h0002);
        next_cycle();
        @(negedge clk);
        check("rstmid_c1_flags", flags(), 16'h0042);
        check("rstmid_c1_state", {14'd0, dbg_state}, {14'd0, S_A});
        #1 rst = 1'b1;
        #1;
        check("rstmid_state", {14'd0, dbg_state}, {14'd0, S_I});
        check_bit("rstmid_mem_en", mem_en, 1'b0);
        check_bit("rstmid_mem_wr", mem_wr, 1'b0);
        check_bit("rstmid_dm_done", dm_done, 1'b0);
        check("rstmid_mem_addr", mem_addr, 16'h0000);
        check("rstmid_mem_wdata", mem_wdata, 16'h0000);
        check("rstmid_dm_rdata", dm_rdata, 16'h0000);
        check("rstmid_if_rdata", if_rdata, 16'h0000);
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("rstmid_after_c%0d_flags", c), flags(), 16'h0000);
        end
        check("rstmid_mem_unchanged", mem[16'h0030], 16'hAAAA);

        // Misaligned DM read at 0x21.
        next_cycle();
        drive(1'b0, 16'h0, 1'b1, 1'b0, 16'h0021, 16'h0);
        @(negedge clk);
        check("align_c0_flags", flags(), 16'h0002);
`ifdef MEM_ARB_ALIGN_CHK_EN
        next_cycle();
        @(negedge clk);
        check("align_c1_flags", flags(), 16'h0009);
        check("align_c1_state", {14'd0, dbg_state}, {14'd0, S_R});
        check("align_c1_dm_rdata", dm_rdata, 16'h0000);
        next_cycle();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        check("align_c2_flags", flags(), 16'h0000);
        check("align_c2_state", {14'd0, dbg_state}, {14'd0, S_I});
`else
        next_cycle();
        @(negedge clk);
        check("align_c1_flags", flags(), 16'h0042);
        next_cycle();
        @(negedge clk);
        check("align_c2_flags", flags(), 16'h0042);
        next_cycle();
        @(negedge clk);
        check("align_c3_flags", flags(), 16'h0008);
        check("align_c3_dm_rdata", dm_rdata, 16'h7777);
        next_cycle();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        check("align_c4_state", {14'd0, dbg_state}, {14'd0, S_I});
`endif

        // ---------------- final report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
